load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Memory stage that consumes the ALU result (`SUM`) as the effective address and `rs2` as store data. It executes RV32I loads and stores against a single-port data memory with a req/gnt/rvalid handshake. It stalls the pipeline while a transaction is outstanding, then returns the load result, sign- or zero-extended. It sits between the ALU and the writeback mux.

Parameters:
DATA_WIDTH, 32, data width; only 32 is supported (fixed 4 byte lanes)
ADDR_WIDTH, 32, byte address width of `lsu_addr` and `mem_addr`

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
lsu_valid  input  1  memory op present; held by upstream while `lsu_stall`=1
lsu_we  input  1  1=store, 0=load
lsu_funct3  input  3  RV32I width/sign code
lsu_addr  input  ADDR_WIDTH  effective byte address (ALU `SUM`)
lsu_wdata  input  DATA_WIDTH  store data (`rs2`)
lsu_stall  output  1  freeze upstream pipeline
lsu_done  output  1  one-cycle pulse: op complete, `lsu_rdata` valid
lsu_rdata  output  DATA_WIDTH  extended load result, registered
lsu_misalign  output  1  misaligned-access flag, valid with `lsu_done`
mem_req  output  1  memory request
mem_we  output  1  memory write enable
mem_addr  output  ADDR_WIDTH  word-aligned address, bits [1:0]=0
mem_be  output  4  byte enables
mem_wdata  output  DATA_WIDTH  lane-replicated store data
mem_gnt  input  1  request accepted this cycle
mem_rvalid  input  1  read data valid; earliest one cycle after `mem_gnt`
mem_rdata  input  DATA_WIDTH  read word

Behaviour:
- Reset (async, `rst_n`=0):
  - state=IDLE.
  - `mem_req`, `mem_we`, `mem_addr`, `mem_be`, `mem_wdata`, `lsu_rdata`, `lsu_done`, `lsu_misalign` all 0.
  - `lsu_stall` forced 0 while `rst_n`=0.
  - Reset mid-transaction drops `mem_req` immediately; an in-flight `mem_rvalid` after reset is ignored.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If `lsu_valid`=1: register `lsu_we`, `lsu_funct3`, `lsu_addr`, `lsu_wdata`, then go to REQ.
  - The `mem_*` outputs are registered from the captured values: `mem_req`=1 from the cycle after accept.
- REQ:
  - `mem_req` is held with stable outputs until `mem_gnt`=1.
  - On gnt: store goes to DONE; load goes to WAIT.
- WAIT:
  - On `mem_rvalid`=1: shift `mem_rdata` right by 8*addr[1:0], extend, register into `lsu_rdata`, go to DONE.
  - `mem_rvalid` in any other state is ignored.
- DONE:
  - `lsu_done`=1 for exactly one cycle, then go to IDLE.
  - `lsu_rdata` holds until the next load completes; stores do not update it.
- `lsu_stall` = (IDLE & `lsu_valid`) | REQ | WAIT, combinational.
  - It is 0 in DONE, so the pipeline advances on the `lsu_done` cycle.
  - `lsu_valid` is ignored outside IDLE.
- Minimum latency, accept cycle to `lsu_done`:
  - Store: 2 cycles with gnt on the first REQ cycle.
  - Load: 3 cycles with gnt immediate and rvalid on the next cycle.
- `lsu_funct3` decode:
  - 000 B, signed
  - 001 H, signed
  - 010 W
  - 100 BU
  - 101 HU
  - 011/110/111 treated as W
  - For stores, only the size matters.
- Byte enables:
  - B: 4'b0001<<a[1:0]
  - H: 4'b0011<<{a[1],1'b0}
  - W: 4'b1111
- Store data: B replicates wdata[7:0] ×4; H replicates wdata[15:0] ×2; W passes through.
- `mem_addr` = {addr[ADDR_WIDTH-1:2],2'b00}.

Optional Feature:
Macro `LSU_MISALIGN_TRAP_EN`.
- Defined:
  - A halfword access with a[0]=1, or a word access with a[1:0]≠0, issues no memory transaction.
  - The FSM goes IDLE→DONE directly.
  - `lsu_done`=1 and `lsu_misalign`=1 together; `lsu_rdata` is unchanged.
- Undefined:
  - Low address bits are masked per size (H clears a[0], W clears a[1:0]) and the access proceeds normally.
  - `lsu_misalign` is tied 0.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, gnt immediate → `mem_addr`=0x100, `mem_be`=1111, `mem_we`=1; `lsu_done` 2 cycles after accept; `lsu_stall` high for exactly 2 cycles.
- SB addr=0x103, wdata=0x000000A5 → `mem_be`=1000, `mem_wdata`=0xA5A5A5A5.
- LB addr=0x102, rdata=0x1280FF00 → `lsu_rdata`=0xFFFFFF80. LBU on the same data → 0x00000080. LH addr=0x102 → 0x00001280.
- LW with gnt delayed 3 cycles and rvalid delayed 2 more → `mem_req` held stable for 4 cycles; `lsu_done` exactly once; `lsu_rdata`=`mem_rdata`.
- `rst_n` pulled low in WAIT, then `mem_rvalid` pulses after release → all outputs 0; no `lsu_done`; state IDLE.
- LH addr=0x101: with `LSU_MISALIGN_TRAP_EN`, `mem_req` is never raised and `lsu_done`=`lsu_misalign`=1 one cycle after accept. Without it, `mem_be`=0011 at `mem_addr`=0x100.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I load/store unit: drives a req/gnt/rvalid data memory port and stalls upstream while busy.
// Optional LSU_MISALIGN_TRAP_EN: misaligned H/W accesses complete at once with lsu_misalign set.
module load_store_unit #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  lsu_valid,
   input  logic                  lsu_we,
   input  logic [2:0]            lsu_funct3,
   input  logic [ADDR_WIDTH-1:0] lsu_addr,
   input  logic [DATA_WIDTH-1:0] lsu_wdata,
   output logic                  lsu_stall,
   output logic                  lsu_done,
   output logic [DATA_WIDTH-1:0] lsu_rdata,
   output logic                  lsu_misalign,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [3:0]            mem_be,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_gnt,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam int unsigned SHW = 5;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t                  state_q, state_d;
   logic                    we_q, we_d;
   logic [2:0]              f3_q, f3_d;
   logic [1:0]              off_q, off_d;
   logic                    mem_req_d, mem_we_d, done_d, misalign_d;
   logic [ADDR_WIDTH-1:0]   mem_addr_d;
   logic [3:0]              mem_be_d;
   logic [DATA_WIDTH-1:0]   mem_wdata_d, rdata_d;

   logic [1:0]              off_c;
   logic [3:0]              be_c;
   logic [DATA_WIDTH-1:0]   wdata_c, shifted_c, ext_c;
`ifdef LSU_MISALIGN_TRAP_EN
   logic                    misal_c;
`endif

   // Access size decode: lane offset masked to the natural alignment of the size
   always_comb begin
      off_c   = 2'b00;
      be_c    = 4'b1111;
      wdata_c = lsu_wdata;
      unique case (lsu_funct3[1:0])
         2'b00: begin
            off_c   = lsu_addr[1:0];
            be_c    = 4'b0001 << lsu_addr[1:0];
            wdata_c = {4{lsu_wdata[7:0]}};
         end
         2'b01: begin
            off_c   = {lsu_addr[1], 1'b0};
            be_c    = 4'b0011 << {lsu_addr[1], 1'b0};
            wdata_c = {2{lsu_wdata[15:0]}};
         end
         default: ;
      endcase
   end

`ifdef LSU_MISALIGN_TRAP_EN
   always_comb begin
      misal_c = 1'b0;
      if (lsu_funct3[1:0] == 2'b01)
         misal_c = lsu_addr[0];
      else if (lsu_funct3[1] == 1'b1)
         misal_c = (lsu_addr[1:0] != 2'b00);
   end
`endif

   // Load result: move addressed lane to bit 0, then sign/zero extend
   always_comb begin
      shifted_c = mem_rdata >> SHW'({off_q, 3'b000});
      ext_c     = shifted_c;
      unique case (f3_q[1:0])
         2'b00:   ext_c = {{24{~f3_q[2] & shifted_c[7]}}, shifted_c[7:0]};
         2'b01:   ext_c = {{16{~f3_q[2] & shifted_c[15]}}, shifted_c[15:0]};
         default: ;
      endcase
   end

   assign lsu_stall = rst_n & (((state_q == IDLE) & lsu_valid) | (state_q == REQ) | (state_q == WAIT));

   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      f3_d        = f3_q;
      off_d       = off_q;
      mem_req_d   = mem_req;
      mem_we_d    = mem_we;
      mem_addr_d  = mem_addr;
      mem_be_d    = mem_be;
      mem_wdata_d = mem_wdata;
      rdata_d     = lsu_rdata;
      done_d      = 1'b0;
      misalign_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (lsu_valid) begin
               we_d        = lsu_we;
               f3_d        = lsu_funct3;
               off_d       = off_c;
               mem_we_d    = lsu_we;
               mem_addr_d  = {lsu_addr[ADDR_WIDTH-1:2], 2'b00};
               mem_be_d    = be_c;
               mem_wdata_d = wdata_c;
`ifdef LSU_MISALIGN_TRAP_EN
               if (misal_c) begin
                  state_d    = DONE;
                  done_d     = 1'b1;
                  misalign_d = 1'b1;
               end else begin
                  state_d   = REQ;
                  mem_req_d = 1'b1;
               end
`else
               state_d   = REQ;
               mem_req_d = 1'b1;
`endif
            end
         end
         REQ: begin
            if (mem_gnt) begin
               mem_req_d = 1'b0;
               if (we_q) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (mem_rvalid) begin
               rdata_d = ext_c;
               state_d = DONE;
               done_d  = 1'b1;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         we_q         <= 1'b0;
         f3_q         <= 3'b000;
         off_q        <= 2'b00;
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_be       <= 4'b0000;
         mem_wdata    <= '0;
         lsu_rdata    <= '0;
         lsu_done     <= 1'b0;
         lsu_misalign <= 1'b0;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         f3_q         <= f3_d;
         off_q        <= off_d;
         mem_req      <= mem_req_d;
         mem_we       <= mem_we_d;
         mem_addr     <= mem_addr_d;
         mem_be       <= mem_be_d;
         mem_wdata    <= mem_wdata_d;
         lsu_rdata    <= rdata_d;
         lsu_done     <= done_d;
         lsu_misalign <= misalign_d;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit with a byte-lane reference model and a reactive memory responder.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        lsu_valid, lsu_we;
   logic [2:0]  lsu_funct3;
   logic [31:0] lsu_addr, lsu_wdata;
   logic        lsu_stall, lsu_done, lsu_misalign;
   logic [31:0] lsu_rdata;
   logic        mem_req, mem_we, mem_gnt, mem_rvalid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_rdata = 32'h0;

   load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .lsu_valid(lsu_valid), .lsu_we(lsu_we), .lsu_funct3(lsu_funct3),
      .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
      .lsu_stall(lsu_stall), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
      .lsu_misalign(lsu_misalign),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // One transaction: model computes lanes/result from size and byte offset; memory answers after gd/rvd cycles
   task automatic do_op(input bit we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int gd, input int rvd, input logic [31:0] rd);
      int          sz, o, exp_done, req_cycles, gnt_cyc;
      bit          mis, trap, rv_sent, done_seen;
      logic [31:0] ewd, mask, v;
      logic [3:0]  ebe;
      sz   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      mis  = (a % sz) != 0;
      o    = int'(a % 4) / sz * sz;
      ebe  = 4'(((1 << sz) - 1) << o);
      ewd  = (sz == 1) ? 32'(wd[7:0]) * 32'h01010101 :
             (sz == 2) ? 32'(wd[15:0]) * 32'h00010001 : wd;
`ifdef LSU_MISALIGN_TRAP_EN
      trap = mis;
`else
      trap = 1'b0;
`endif
      exp_done   = trap ? 1 : (we ? gd + 2 : gd + rvd + 2);
      req_cycles = 0;
      gnt_cyc    = -1;
      rv_sent    = 1'b0;
      done_seen  = 1'b0;
      if (!we && !trap) begin
         v = rd >> (8 * o);
         if (sz < 4) begin
            mask = 32'((64'd1 << (8 * sz)) - 1);
            v    = v & mask;
            if (!f3[2] && v[8*sz-1]) v = v | ~mask;
         end
         exp_rdata = v;
      end

      @(negedge clk);
      lsu_valid = 1'b1; lsu_we = we; lsu_funct3 = f3; lsu_addr = a; lsu_wdata = wd;
      #1 check("stall_accept", 32'(lsu_stall), 32'd1);
      @(posedge clk);
      #1 lsu_valid = 1'b0; lsu_addr = $urandom; lsu_wdata = $urandom; lsu_funct3 = 3'($urandom);

      for (int cyc = 1; cyc <= 80 && !done_seen; cyc++) begin
         @(negedge clk);
         mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
         if (lsu_done) begin
            done_seen = 1'b1;
            check("done_cycle", 32'(cyc), 32'(exp_done));
            check("stall_done", 32'(lsu_stall), 32'd0);
            check("rdata", lsu_rdata, exp_rdata);
            check("misalign", 32'(lsu_misalign), 32'(trap));
            check("req_cycles", 32'(req_cycles), trap ? 32'd0 : 32'(gd + 1));
         end else begin
            check("stall_busy", 32'(lsu_stall), 32'd1);
            if (mem_req) begin
               req_cycles++;
               check("mem_addr", mem_addr, {a[31:2], 2'b00});
               check("mem_be", 32'(mem_be), 32'(ebe));
               check("mem_we", 32'(mem_we), 32'(we));
               if (we) check("mem_wdata", mem_wdata, ewd);
               if (req_cycles > gd) begin
                  mem_gnt = 1'b1;
                  gnt_cyc = cyc;
               end
            end else if (gnt_cyc > 0 && !we && !rv_sent && cyc - gnt_cyc >= rvd) begin
               mem_rvalid = 1'b1;
               mem_rdata  = rd;
               rv_sent    = 1'b1;
            end
         end
      end
      if (!done_seen) check("done_timeout", 32'd0, 32'd1);
      @(negedge clk);
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      check("done_pulse", 32'(lsu_done), 32'd0);
      check("stall_idle", 32'(lsu_stall), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_req"}, 32'(mem_req), 32'd0);
      check({tag, "_we"}, 32'(mem_we), 32'd0);
      check({tag, "_addr"}, mem_addr, 32'd0);
      check({tag, "_be"}, 32'(mem_be), 32'd0);
      check({tag, "_wdata"}, mem_wdata, 32'd0);
      check({tag, "_rdata"}, lsu_rdata, 32'd0);
      check({tag, "_done"}, 32'(lsu_done), 32'd0);
      check({tag, "_mis"}, 32'(lsu_misalign), 32'd0);
      check({tag, "_stall"}, 32'(lsu_stall), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; lsu_valid = 1'b1; lsu_we = 1'b0; lsu_funct3 = 3'b010;
      lsu_addr = 32'h0; lsu_wdata = 32'h0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
      #12 check_all_zero("reset");
      lsu_valid = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);

      do_op(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 1, 32'h0);
      do_op(1'b1, 3'b000, 32'h103, 32'h000000A5, 0, 1, 32'h0);
      do_op(1'b0, 3'b000, 32'h102, 32'h0, 0, 1, 32'h1280FF00);
      check("lb_value", lsu_rdata, 32'hFFFFFF80);
      do_op(1'b0, 3'b100, 32'h102, 32'h0, 0, 1, 32'h1280FF00);
      check("lbu_value", lsu_rdata, 32'h00000080);
      do_op(1'b0, 3'b001, 32'h102, 32'h0, 0, 1, 32'h1280FF00);
      check("lh_value", lsu_rdata, 32'h00001280);
      do_op(1'b0, 3'b010, 32'h204, 32'h0, 3, 2, 32'h89ABCDEF);
      check("lw_value", lsu_rdata, 32'h89ABCDEF);
      do_op(1'b0, 3'b001, 32'h101, 32'h0, 0, 1, 32'h55AA7711);
      do_op(1'b1, 3'b001, 32'h101, 32'h0000BEEF, 1, 1, 32'h0);

      // Reset while a load waits for rvalid; a late rvalid must be ignored
      @(negedge clk);
      lsu_valid = 1'b1; lsu_we = 1'b0; lsu_funct3 = 3'b010; lsu_addr = 32'h300;
      @(posedge clk); #1 lsu_valid = 1'b0;
      @(negedge clk); mem_gnt = 1'b1;
      @(negedge clk); mem_gnt = 1'b0;
      rst_n = 1'b0; lsu_valid = 1'b1;
      #1 check_all_zero("rst_wait");
      @(negedge clk); rst_n = 1'b1; lsu_valid = 1'b0;
      @(negedge clk); mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
      @(negedge clk); mem_rvalid = 1'b0;
      exp_rdata = 32'h0;
      for (int i = 0; i < 4; i++) begin
         check_all_zero("post_rst");
         @(negedge clk);
      end

      for (int i = 0; i < 80; i++) begin
         int gap;
         do_op(1'($urandom), 3'($urandom_range(0, 7)), $urandom, $urandom,
               int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), $urandom);
         gap = int'($urandom_range(0, 2));
         for (int g = 0; g < gap; g++) @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
